operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Issue stage directly upstream of register_file. Accepts decoded instructions,
//  reads source operands via register_file's two read ports, and stalls on
//  register hazards using a per-register busy scoreboard. Forwards same-cycle
//  writeback data and hands operands to the execute stage through a
//  one-entry, valid/ready output register.
// PARAMETERS
//  NUM_REGS      8                   architectural registers (all writable, no zero reg)
//  DATA_WIDTH    8                   register/operand width
//  ADDR_WIDTH    $clog2(NUM_REGS)    register index width (3)
//  OPCODE_WIDTH  4                   opcode width, passed through untouched
// PORTS
//  clk           in   1    clock, all state on posedge
//  reset         in   1    synchronous, active-high
//  in_valid      in   1    decoded instruction present
//  in_ready      out  1    stage accepts instruction this cycle
//  in_opcode     in   OPCODE_WIDTH
//  in_rs0/in_rs1 in   ADDR_WIDTH   source register indices
//  in_uses_rs0/1 in   1    source operand is needed
//  in_rd         in   ADDR_WIDTH   destination index
//  in_writes_rd  in   1    instruction will write in_rd
//  in_imm        in   DATA_WIDTH   immediate, passed through
//  rd0_enable/rd1_enable out 1     register_file read enables
//  rd0_addr/rd1_addr     out ADDR_WIDTH
//  rd0_data/rd1_data     in  DATA_WIDTH  register_file read data (combinational read)
//  wb_enable     in   1    writeback commits this cycle (same net drives register_file wr_enable)
//  wb_addr       in   ADDR_WIDTH
//  wb_data       in   DATA_WIDTH
//  out_valid     out  1    operands valid for execute
//  out_ready     in   1    execute accepts
//  out_opcode, out_rd, out_writes_rd, out_imm  out  registered copies of inputs
//  out_op0/out_op1       out  DATA_WIDTH  resolved operands (0 when source unused)
// BEHAVIOUR
//  - Reset: out_valid=0, all out_* data=0, busy[]=0; in_ready=0 and rd*_enable=0 while reset high.
//  - rdN_addr=in_rsN; rdN_enable=in_valid & in_uses_rsN (combinational, not gated by stall).
//  - wb_hit(r) = wb_enable & wb_addr==r.
//  - src hazard: in_uses_rsN & busy[in_rsN] & !wb_hit(in_rsN).
//  - WAW hazard: in_writes_rd & busy[in_rd] & !wb_hit(in_rd).
//  - in_ready = !reset & !hazard & (!out_valid | out_ready). fire = in_valid & in_ready.
//  - Operand resolve: wb_hit(rsN) ? wb_data : rdN_data (bypass beats register_file
//    for the simultaneous read/write case); unused source -> 0.
//  - On fire: output register loads all fields, out_valid=1 next cycle (latency 1).
//  - out_valid & !out_ready & !fire: output register holds every field stable.
//  - out_valid & out_ready & !fire: out_valid->0, data fields hold.
//  - Back-to-back: fire with out_ready=1 sustains 1 instr/cycle.
//  - Scoreboard: busy[wb_addr] cleared on wb_enable; busy[in_rd] set on
//    fire & in_writes_rd; same reg set and clear in one cycle -> set wins.
//  - wb_enable for a non-busy reg is legal; clears nothing extra, no error.
//  - in_* must be held stable while in_valid & !in_ready (upstream rule).
//  - Reset mid-operation: held instruction dropped, busy cleared; pending writebacks
//    after reset are harmless.
// STRUCTURE
//  - cpu_pkg: DATA_WIDTH/ADDR_WIDTH/OPCODE_WIDTH constants, reg_idx_t, data_t,
//    opcode_t, issue_pkt_t struct (opcode, rs0, rs1, uses, rd, writes_rd, imm).
//  - Sub-module reg_scoreboard: busy[NUM_REGS] vector, set/clear ports,
//    two source-lookup + one dest-lookup outputs with wb-hit masking.
//  - Top: hazard logic, bypass muxes, output pipeline register.
// TESTING
//  1. Reset, then in r3: rs0=1,rs1=2 with RF r1=10,r2=20, out_ready=1 -> next cycle out_valid=1, op0=10, op1=20.
//  2. Issue writes_rd rd=4, then instr uses rs0=4 -> in_ready=0 until wb_enable addr=4 data=77;
//     that same cycle fire, op0=77 (bypass).
//  3. out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged, in_ready=0; release -> drains, next accepted.
//  4. WAW: rd=5 busy, new instr writes rd=5 -> stalled; wb addr=5 -> fires same cycle, busy[5]=1 after.
//  5. Same-cycle wb clear and new set of r6 -> busy[6]=1 next cycle; dependent reader of r6 stalls.
//  6. Assert reset with out_valid=1 and busy[2]=1 -> next cycle out_valid=0, busy all 0, r2 reader fires immediately.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand fetch / issue stage.
// Register index, operand and packet definitions.
package operand_fetch_pkg;

    localparam int NUM_REGS     = 8;
    localparam int DATA_WIDTH   = 8;
    localparam int ADDR_WIDTH   = $clog2(NUM_REGS);
    localparam int OPCODE_WIDTH = 4;

    typedef logic [ADDR_WIDTH-1:0]   reg_idx_t;
    typedef logic [DATA_WIDTH-1:0]   data_t;
    typedef logic [OPCODE_WIDTH-1:0] opcode_t;
    typedef logic [NUM_REGS-1:0]     busy_vec_t;

    typedef struct packed {
        opcode_t  opcode;
        reg_idx_t rs0;
        reg_idx_t rs1;
        logic [1:0] uses;
        reg_idx_t rd;
        logic     writes_rd;
        data_t    imm;
    } issue_pkt_t;

    typedef struct packed {
        opcode_t  opcode;
        reg_idx_t rd;
        logic     writes_rd;
        data_t    imm;
        data_t    op0;
        data_t    op1;
    } ex_pkt_t;

    function automatic logic wb_hit(logic en, reg_idx_t addr, reg_idx_t r);
        return en && (addr == r);
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Signal bundle between decode, register file, writeback and execute.
// The slave modport is the operand fetch stage itself.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic     in_valid;
    logic     in_ready;
    opcode_t  in_opcode;
    reg_idx_t in_rs0;
    reg_idx_t in_rs1;
    logic     in_uses_rs0;
    logic     in_uses_rs1;
    reg_idx_t in_rd;
    logic     in_writes_rd;
    data_t    in_imm;

    logic     rd0_enable;
    logic     rd1_enable;
    reg_idx_t rd0_addr;
    reg_idx_t rd1_addr;
    data_t    rd0_data;
    data_t    rd1_data;

    logic     wb_enable;
    reg_idx_t wb_addr;
    data_t    wb_data;

    logic     out_valid;
    logic     out_ready;
    opcode_t  out_opcode;
    reg_idx_t out_rd;
    logic     out_writes_rd;
    data_t    out_imm;
    data_t    out_op0;
    data_t    out_op1;

    modport slave (
        input  in_valid, in_opcode, in_rs0, in_rs1,
        input  in_uses_rs0, in_uses_rs1, in_rd, in_writes_rd, in_imm,
        input  rd0_data, rd1_data,
        input  wb_enable, wb_addr, wb_data,
        input  out_ready,
        output in_ready,
        output rd0_enable, rd1_enable, rd0_addr, rd1_addr,
        output out_valid, out_opcode, out_rd, out_writes_rd,
        output out_imm, out_op0, out_op1
    );

    modport master (
        output in_valid, in_opcode, in_rs0, in_rs1,
        output in_uses_rs0, in_uses_rs1, in_rd, in_writes_rd, in_imm,
        output rd0_data, rd1_data,
        output wb_enable, wb_addr, wb_data,
        output out_ready,
        input  in_ready,
        input  rd0_enable, rd1_enable, rd0_addr, rd1_addr,
        input  out_valid, out_opcode, out_rd, out_writes_rd,
        input  out_imm, out_op0, out_op1
    );

endinterface

// File: rtl/operand_fetch_reg_scoreboard.sv
// Per-register busy bits with writeback-masked lookups.
// A same-cycle set and clear of one register leaves it busy.
module operand_fetch_reg_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  reg_idx_t src0_idx,
    input  reg_idx_t src1_idx,
    input  reg_idx_t dst_idx,
    output logic     src0_busy,
    output logic     src1_busy,
    output logic     dst_busy
);

    busy_vec_t busy_q;
    busy_vec_t busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        if (set_en) busy_d[set_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    // A register being written back this cycle is no longer a hazard.
    assign src0_busy = busy_q[src0_idx] & !wb_hit(clr_en, clr_idx, src0_idx);
    assign src1_busy = busy_q[src1_idx] & !wb_hit(clr_en, clr_idx, src1_idx);
    assign dst_busy  = busy_q[dst_idx]  & !wb_hit(clr_en, clr_idx, dst_idx);

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: hazard stall, writeback bypass and a one-entry
// valid/ready output register toward execute.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic clk,
    input  logic reset,
    operand_fetch_if.slave io
);

    issue_pkt_t pkt;
    ex_pkt_t    ex_d;
    ex_pkt_t    ex_q;
    logic       out_valid_q;
    logic       src0_busy;
    logic       src1_busy;
    logic       dst_busy;
    logic       hazard;
    logic       fire;
    data_t      op0;
    data_t      op1;

    always_comb begin
        pkt.opcode    = io.in_opcode;
        pkt.rs0       = io.in_rs0;
        pkt.rs1       = io.in_rs1;
        pkt.uses      = {io.in_uses_rs1, io.in_uses_rs0};
        pkt.rd        = io.in_rd;
        pkt.writes_rd = io.in_writes_rd;
        pkt.imm       = io.in_imm;
    end

    operand_fetch_reg_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .set_en    (fire & pkt.writes_rd),
        .set_idx   (pkt.rd),
        .clr_en    (io.wb_enable),
        .clr_idx   (io.wb_addr),
        .src0_idx  (pkt.rs0),
        .src1_idx  (pkt.rs1),
        .dst_idx   (pkt.rd),
        .src0_busy (src0_busy),
        .src1_busy (src1_busy),
        .dst_busy  (dst_busy)
    );

    assign hazard = (pkt.uses[0] & src0_busy)
                  | (pkt.uses[1] & src1_busy)
                  | (pkt.writes_rd & dst_busy);

    assign io.in_ready = !reset & !hazard & (!out_valid_q | io.out_ready);
    assign fire        = io.in_valid & io.in_ready;

    assign io.rd0_enable = !reset & io.in_valid & pkt.uses[0];
    assign io.rd1_enable = !reset & io.in_valid & pkt.uses[1];
    assign io.rd0_addr   = pkt.rs0;
    assign io.rd1_addr   = pkt.rs1;

    // Writeback data beats the register file on a simultaneous read/write.
    always_comb begin
        op0 = '0;
        op1 = '0;
        if (pkt.uses[0]) begin
            op0 = wb_hit(io.wb_enable, io.wb_addr, pkt.rs0)
                ? io.wb_data : io.rd0_data;
        end
        if (pkt.uses[1]) begin
            op1 = wb_hit(io.wb_enable, io.wb_addr, pkt.rs1)
                ? io.wb_data : io.rd1_data;
        end
    end

    always_comb begin
        ex_d.opcode    = pkt.opcode;
        ex_d.rd        = pkt.rd;
        ex_d.writes_rd = pkt.writes_rd;
        ex_d.imm       = pkt.imm;
        ex_d.op0       = op0;
        ex_d.op1       = op1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            ex_q        <= '0;
        end else if (fire) begin
            out_valid_q <= 1'b1;
            ex_q        <= ex_d;
        end else if (io.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign io.out_valid     = out_valid_q;
    assign io.out_opcode    = ex_q.opcode;
    assign io.out_rd        = ex_q.rd;
    assign io.out_writes_rd = ex_q.writes_rd;
    assign io.out_imm       = ex_q.imm;
    assign io.out_op0       = ex_q.op0;
    assign io.out_op1       = ex_q.op1;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch with a behavioural issue model
// and a model register file driving the read ports.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_fetch_if ifc ();

    operand_fetch dut (
        .clk   (clk),
        .reset (rst),
        .io    (ifc)
    );

    logic [7:0] rf [8];
    assign ifc.rd0_data = rf[ifc.rd0_addr];
    assign ifc.rd1_data = rf[ifc.rd1_addr];

    int checks = 0;
    int errors = 0;

    bit s_reset = 1'b1;
    bit s_valid, s_u0, s_u1, s_w, s_wb_en, s_oready;
    logic [3:0] s_opc;
    logic [2:0] s_rs0, s_rs1, s_rd, s_wb_addr;
    logic [7:0] s_imm, s_wb_data;

    bit m_busy [8];
    bit m_full;
    bit m_fire;
    logic [31:0] exp_q [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit hit(logic [2:0] r);
        return s_wb_en && (s_wb_addr == r);
    endfunction

    function automatic logic [7:0] opnd(bit u, logic [2:0] r);
        if (!u) return 8'd0;
        return hit(r) ? s_wb_data : rf[r];
    endfunction

    task automatic instr(bit v, logic [3:0] opc, logic [2:0] r0, bit u0,
                         logic [2:0] r1, bit u1, logic [2:0] rd, bit w,
                         logic [7:0] imm);
        s_valid = v; s_opc = opc; s_rs0 = r0; s_u0 = u0;
        s_rs1 = r1; s_u1 = u1; s_rd = rd; s_w = w; s_imm = imm;
    endtask

    task automatic wb(bit en, logic [2:0] a, logic [7:0] d);
        s_wb_en = en; s_wb_addr = a; s_wb_data = d;
    endtask

    task automatic step();
        bit hz, er;
        @(negedge clk);
        rst = s_reset;
        ifc.in_valid = s_valid;    ifc.in_opcode = s_opc;
        ifc.in_rs0 = s_rs0;        ifc.in_rs1 = s_rs1;
        ifc.in_uses_rs0 = s_u0;    ifc.in_uses_rs1 = s_u1;
        ifc.in_rd = s_rd;          ifc.in_writes_rd = s_w;
        ifc.in_imm = s_imm;        ifc.out_ready = s_oready;
        ifc.wb_enable = s_wb_en;   ifc.wb_addr = s_wb_addr;
        ifc.wb_data = s_wb_data;
        #1;
        hz = (s_u0 && m_busy[s_rs0] && !hit(s_rs0))
          || (s_u1 && m_busy[s_rs1] && !hit(s_rs1))
          || (s_w && m_busy[s_rd] && !hit(s_rd));
        er = !s_reset && !hz && (!m_full || s_oready);
        check("in_ready", ifc.in_ready, er);
        check("rd_en", {ifc.rd0_enable, ifc.rd1_enable},
              {!s_reset && s_valid && s_u0, !s_reset && s_valid && s_u1});
        check("rd_addr", {ifc.rd0_addr, ifc.rd1_addr}, {s_rs0, s_rs1});
        check("out_valid", ifc.out_valid, m_full);
        m_fire = s_valid && er;
        if (m_fire)
            exp_q.push_back({s_opc, s_rd, s_w, s_imm,
                             opnd(s_u0, s_rs0), opnd(s_u1, s_rs1)});
        @(posedge clk);
        if (s_wb_en) rf[s_wb_addr] <= s_wb_data;
        if (s_reset) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_full = 1'b0;
            exp_q.delete();
        end else begin
            m_full = m_fire || (m_full && !s_oready);
            if (s_wb_en) m_busy[s_wb_addr] = 1'b0;
            if (m_fire && s_w) m_busy[s_rd] = 1'b1;
        end
    endtask

    function automatic logic [31:0] out_pkt();
        return {ifc.out_opcode, ifc.out_rd, ifc.out_writes_rd,
                ifc.out_imm, ifc.out_op0, ifc.out_op1};
    endfunction

    // Monitor: every accepted output must match the oldest expected packet.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && ifc.out_valid && ifc.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_pkt actual=%0h expected=none", out_pkt());
                end else begin
                    check("out_pkt", out_pkt(), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [2:0] bl [$];
        for (int i = 0; i < 8; i++) rf[i] = 8'(i * 10);
        rst = 1'b1;
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb(0, 0, 0);
        s_oready = 1'b1;

        s_reset = 1'b1;
        step(); step();
        #1;
        check("reset_out", {ifc.out_valid, out_pkt()}, 33'd0);
        s_reset = 1'b0;

        // 1: plain read
        instr(1, 4'h1, 1, 1, 2, 1, 3, 0, 8'h11); step();
        #1;
        check("t1_ops", {ifc.out_op0, ifc.out_op1}, {8'd10, 8'd20});
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // 2: RAW stall then bypass
        instr(1, 4'h2, 0, 0, 0, 0, 4, 1, 8'h00); step();
        instr(1, 4'h3, 4, 1, 0, 0, 1, 0, 8'h00); step(); step();
        wb(1, 4, 8'd77); step();
        #1;
        check("t2_bypass", ifc.out_op0, 8'd77);
        wb(0, 0, 0);
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // 3: output backpressure
        s_oready = 1'b0;
        instr(1, 4'h3, 1, 1, 0, 0, 7, 0, 8'h5A); step();
        instr(1, 4'h4, 2, 1, 0, 0, 6, 0, 8'h33);
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            check("t3_hold", out_pkt(),
                  {4'h3, 3'd7, 1'b0, 8'h5A, 8'd10, 8'd0});
        end
        s_oready = 1'b1; step();
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // 4: WAW
        instr(1, 4'h5, 0, 0, 0, 0, 5, 1, 8'h00); step();
        instr(1, 4'h6, 0, 0, 0, 0, 5, 1, 8'h44); step();
        wb(1, 5, 8'd55); step();
        wb(0, 0, 0);
        instr(1, 4'h7, 5, 1, 0, 0, 0, 0, 8'h00); step();
        wb(1, 5, 8'd56); step();
        wb(0, 0, 0);
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // 5: same-cycle clear and set
        instr(1, 4'h8, 0, 0, 0, 0, 6, 1, 8'h00); step();
        wb(1, 6, 8'd60);
        instr(1, 4'h9, 0, 0, 0, 0, 6, 1, 8'h00); step();
        wb(0, 0, 0);
        instr(1, 4'hA, 6, 1, 6, 1, 0, 0, 8'h00); step();
        wb(1, 6, 8'd61); step();
        wb(0, 0, 0);
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // 6: reset mid-operation
        s_oready = 1'b0;
        instr(1, 4'hB, 0, 0, 0, 0, 2, 1, 8'h00); step();
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        s_reset = 1'b1; step();
        #1;
        check("t6_reset", ifc.out_valid, 1'b0);
        s_reset = 1'b0;
        s_oready = 1'b1;
        instr(1, 4'hC, 2, 1, 0, 0, 1, 0, 8'h00); step();
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!(s_valid && !m_fire)) begin
                instr($urandom_range(9) < 7, 4'($urandom),
                      3'($urandom), $urandom_range(3) != 0,
                      3'($urandom), $urandom_range(3) != 0,
                      3'($urandom), $urandom_range(1) == 1,
                      8'($urandom));
            end
            s_oready = $urandom_range(9) < 7;
            s_reset = (c % 700) == 350;
            wb(0, 0, 0);
            if ($urandom_range(9) < 4) begin
                bl.delete();
                for (int i = 0; i < 8; i++) if (m_busy[i]) bl.push_back(3'(i));
                if (bl.size() > 0 && $urandom_range(3) != 0)
                    wb(1, bl[$urandom_range(bl.size() - 1)], 8'($urandom));
                else
                    wb(1, 3'($urandom), 8'($urandom));
            end
            step();
        end

        s_reset = 1'b0;
        s_oready = 1'b1;
        wb(0, 0, 0);
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); step(); step();
        check("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
